width_upsizer_buffer: RTL and testbench
=======================================

Name: width_upsizer_buffer

Overview:
- Access-enable packing stage placed directly downstream of a bypass buffer.
- Consumes narrow WIDTH-bit words and emits one RATIO*WIDTH-bit word per RATIO accepted writes.
- Both sides use the same access-enable handshake as the bypass buffer: write_enable/full upstream, read_enable/empty downstream. This lets the block chain directly behind a bypass buffer or ahead of a wide FIFO.
- Contains one staging register for partial words and one output register, so the next wide word can assemble while the previous one waits to be read.

Parameters:
- WIDTH, 8, width of each narrow input word.
- RATIO, 4, number of narrow words per output word; RATIO >= 2; need not be a power of two.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- write_enable  input  1  write request; accepted when write_enable && !full.
- write_data  input  WIDTH  narrow word; sampled on an accepted write.
- full  output  1  buffer cannot accept a write this cycle.
- read_enable  input  1  read request; accepted when read_enable && !empty.
- read_data  output  RATIO*WIDTH  current output-register content.
- empty  output  1  no wide word is available.

Behaviour:
- Reset (asynchronous assert, synchronous release): lane counter = 0, staging = 0, output register = 0, output_valid = 0. Hence full = 0, empty = 1, read_data = 0.
- Lane order: the first accepted word goes to bits [WIDTH-1:0], the k-th word (0-based) to bits [(k+1)*WIDTH-1 : k*WIDTH].
- Lane counter: counts 0..RATIO-1 and wraps to 0 after the last lane. Width is clog2(RATIO), minimum 1.
- Accepted write with counter < RATIO-1: store the word in lane[counter]; counter++.
- Accepted write with counter == RATIO-1 (completing write):
  - next output register = {write_data, staging lanes 0..RATIO-2}.
  - output_valid = 1; counter = 0.
- full = output_valid && (counter == RATIO-1). Registered only; no combinational path from read_enable.
- empty = !output_valid. Registered.
- read_data is driven from the output register only; there is no bypass of write_data to read_data.
- Latency: the wide word is readable the cycle after its completing write.
- Accepted read with no completing write: output_valid = 0; the output register keeps its value.
- Same-cycle completing write and accepted read: output register is reloaded with the new word; output_valid stays 1.
- Non-completing write concurrent with a read: the two are independent.
- Write while full: ignored; no state change.
- Read while empty: ignored; read_data unchanged.
- After a read that drops full, full deasserts on the next cycle. Sustained throughput is one narrow word per cycle, with one bubble only when the downstream consumer stalls.
- Reset asserted mid-packing discards partial lanes and any pending wide word immediately. Outputs return to reset values asynchronously.
- Staging lanes are not cleared after a completed word. They are overwritten lane by lane.

Optional Feature:
- Macro: WIDTH_UPSIZER_BUFFER_FLUSH_EN.
- When defined, add two ports:
  - flush, input 1: level request to emit a partial word.
  - read_count, output clog2(RATIO+1): number of valid lanes in read_data; resets to 0.
- Flush takes effect in a cycle where flush is high, the effective lane count is > 0, and the output register is free (!output_valid, or an accepted read this cycle).
  - Effective lane count includes a same-cycle accepted write.
  - Action: move the partial lanes to the output register with unused upper lanes forced to 0. read_count = lane count; counter = 0; output_valid = 1.
- A completing write overrides flush; read_count = RATIO.
- Flush with an effective lane count of 0 is a no-op.
- Flush while the output register is busy has no effect; the requester holds flush.
- When undefined: no flush or read_count ports. Partial words remain staged until completed.

Test Plan:
- Reset then idle, WIDTH=8, RATIO=4 -> empty=1, full=0, read_data=0 for 10 cycles.
- Write 0x11,0x22,0x33,0x44 on consecutive cycles, no reads -> empty=0 the cycle after the 4th write; read_data=0x44332211; full=0.
- Keep writing 0x55,0x66,0x77 without reading -> full=1 after the 7th write; an 8th write of 0x88 held 3 cycles is ignored. Read -> returns 0x44332211; full=0 next cycle; 0x88 then accepted; next read returns 0x88776655.
- Continuous writes of 0x00..0x3F with read_enable held high whenever !empty -> 16 wide words in order, first 0x03020100; no write stalls (full never 1).
- Reset pulse after 2 of 4 writes, then write 0xA0..0xA3 -> only 0xA3A2A1A0 is produced; no stale lanes.
- With WIDTH_UPSIZER_BUFFER_FLUSH_EN: write 0x11,0x22 then flush for 1 cycle -> read_data=0x00002211, read_count=2; flush while empty and counter 0 -> no change.

Source files
------------

// File: rtl/width_upsizer_buffer.sv
// Packs RATIO narrow WIDTH-bit words into one wide word behind write_enable/full, read_enable/empty handshakes.
// Optional partial-word flush with lane count is enabled by defining WIDTH_UPSIZER_BUFFER_FLUSH_EN.
module width_upsizer_buffer #(
   parameter int WIDTH = 8,
   parameter int RATIO = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     write_enable,
   input  logic [WIDTH-1:0]         write_data,
   output logic                     full,
   input  logic                     read_enable,
   output logic [RATIO*WIDTH-1:0]   read_data,
`ifdef WIDTH_UPSIZER_BUFFER_FLUSH_EN
   input  logic                     flush,
   output logic [$clog2(RATIO+1)-1:0] read_count,
`endif
   output logic                     empty
);

   localparam int CNT_W = ($clog2(RATIO) < 1) ? 1 : $clog2(RATIO);
   localparam int SW    = (RATIO-1)*WIDTH;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO-1);

   logic [CNT_W-1:0]       cnt_q,   cnt_d;
   logic [SW-1:0]          stage_q, stage_d;
   logic [RATIO*WIDTH-1:0] out_q,   out_d;
   logic                   ovld_q,  ovld_d;
   logic                   wr_acc, rd_acc, complete;

   assign full      = ovld_q && (cnt_q == LAST);
   assign empty     = !ovld_q;
   assign read_data = out_q;
   assign wr_acc    = write_enable && !full;
   assign rd_acc    = read_enable && ovld_q;
   assign complete  = wr_acc && (cnt_q == LAST);

`ifdef WIDTH_UPSIZER_BUFFER_FLUSH_EN
   localparam int RC_W = $clog2(RATIO+1);
   logic [RC_W-1:0] rc_q, rc_d, eff_cnt;
   logic            flush_go;
   assign read_count = rc_q;
`endif

   always_comb begin
      cnt_d   = cnt_q;
      stage_d = stage_q;
      out_d   = out_q;
      ovld_d  = ovld_q;
      if (wr_acc && !complete) begin
         for (int i = 0; i < RATIO-1; i++) begin
            if (cnt_q == CNT_W'(i)) stage_d[i*WIDTH +: WIDTH] = write_data;
         end
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (complete) begin
         // The last lane comes straight from write_data so the word is ready next cycle.
         out_d  = {write_data, stage_q};
         ovld_d = 1'b1;
         cnt_d  = '0;
      end else if (rd_acc) begin
         ovld_d = 1'b0;
      end
`ifdef WIDTH_UPSIZER_BUFFER_FLUSH_EN
      rc_d     = rc_q;
      eff_cnt  = RC_W'(cnt_q) + RC_W'(wr_acc && !complete);
      flush_go = flush && !complete && (eff_cnt != '0) && (!ovld_q || rd_acc);
      if (complete) rc_d = RC_W'(RATIO);
      if (flush_go) begin
         // Lanes above the count may hold stale data from an earlier word; zero them.
         out_d = '0;
         for (int i = 0; i < RATIO-1; i++) begin
            if (i < int'(eff_cnt)) out_d[i*WIDTH +: WIDTH] = stage_d[i*WIDTH +: WIDTH];
         end
         ovld_d = 1'b1;
         cnt_d  = '0;
         rc_d   = eff_cnt;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         stage_q <= '0;
         out_q   <= '0;
         ovld_q  <= 1'b0;
`ifdef WIDTH_UPSIZER_BUFFER_FLUSH_EN
         rc_q    <= '0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         out_q   <= out_d;
         ovld_q  <= ovld_d;
`ifdef WIDTH_UPSIZER_BUFFER_FLUSH_EN
         rc_q    <= rc_d;
`endif
      end
   end

endmodule

// File: tb/tb_width_upsizer_buffer.sv
// Scoreboard bench for width_upsizer_buffer (WIDTH=8, RATIO=4) with directed vectors.
module tb_width_upsizer_buffer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        write_enable = 1'b0;
   logic [7:0]  write_data = '0;
   logic        read_enable = 1'b0;
   logic        full, empty;
   logic [31:0] read_data;
`ifdef WIDTH_UPSIZER_BUFFER_FLUSH_EN
   logic        flush = 1'b0;
   logic [2:0]  read_count;
`endif

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];
   logic        full_seen;

   width_upsizer_buffer #(.WIDTH(8), .RATIO(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .write_enable (write_enable),
      .write_data   (write_data),
      .full         (full),
      .read_enable  (read_enable),
      .read_data    (read_data),
`ifdef WIDTH_UPSIZER_BUFFER_FLUSH_EN
      .flush        (flush),
      .read_count   (read_count),
`endif
      .empty        (empty)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [7:0] d);
      write_enable = 1'b1;
      write_data   = d;
      tick();
      write_enable = 1'b0;
   endtask

   initial begin
      // Monitor: every accepted read pops the scoreboard and compares read_data.
      fork
         forever begin
            @(negedge clock);
            if (!reset && read_enable && !empty) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_read: got %h expected no word", read_data);
               end else begin
                  check("read_word", read_data, exp_q.pop_front());
               end
            end
         end
      join_none

      // Reset and idle
      #2;
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_data", read_data, 32'h0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_empty", 32'(empty), 32'd1);
         check("idle_full", 32'(full), 32'd0);
         check("idle_data", read_data, 32'h0);
      end

      // First word, no reads
      wr(8'h11); wr(8'h22); wr(8'h33);
      check("partial_empty", 32'(empty), 32'd1);
      wr(8'h44);
      exp_q.push_back(32'h44332211);
      check("w1_empty", 32'(empty), 32'd0);
      check("w1_data", read_data, 32'h44332211);
      check("w1_full", 32'(full), 32'd0);

      // Fill staging until full, then hold a write that must be ignored
      wr(8'h55); wr(8'h66);
      check("pre_full", 32'(full), 32'd0);
      wr(8'h77);
      check("full_set", 32'(full), 32'd1);
      exp_q.push_back(32'h88776655);
      write_enable = 1'b1;
      write_data   = 8'h88;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("held_full", 32'(full), 32'd1);
         check("held_data", read_data, 32'h44332211);
      end
      read_enable = 1'b1;
      tick();
      read_enable = 1'b0;
      check("drop_full", 32'(full), 32'd0);
      check("drop_empty", 32'(empty), 32'd1);
      tick();
      write_enable = 1'b0;
      check("w2_empty", 32'(empty), 32'd0);
      check("w2_full", 32'(full), 32'd0);
      check("w2_data", read_data, 32'h88776655);
      read_enable = 1'b1;
      tick();
      read_enable = 1'b0;
      check("w2_read_empty", 32'(empty), 32'd1);

      // Streaming with reads always enabled
      for (int k = 0; k < 16; k++)
         exp_q.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
      full_seen   = 1'b0;
      read_enable = 1'b1;
      for (int k = 0; k < 64; k++) begin
         write_enable = 1'b1;
         write_data   = 8'(k);
         tick();
         if (full) full_seen = 1'b1;
      end
      write_enable = 1'b0;
      repeat (3) tick();
      read_enable = 1'b0;
      check("stream_no_full", 32'(full_seen), 32'd0);
      check("stream_drained", 32'(exp_q.size()), 32'd0);
      check("stream_last", read_data, 32'h3F3E3D3C);

      // Reset mid-packing discards partial lanes immediately
      wr(8'h01); wr(8'h02);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_data", read_data, 32'h0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_full", 32'(full), 32'd0);
      tick();
      reset = 1'b0;
      exp_q.push_back(32'hA3A2A1A0);
      wr(8'hA0); wr(8'hA1); wr(8'hA2); wr(8'hA3);
      check("post_rst_data", read_data, 32'hA3A2A1A0);
      read_enable = 1'b1;
      tick();
      read_enable = 1'b0;
      check("post_rst_empty", 32'(empty), 32'd1);

`ifdef WIDTH_UPSIZER_BUFFER_FLUSH_EN
      // Flush a two-lane partial word; stale upper lanes must read as zero
      wr(8'h11); wr(8'h22);
      exp_q.push_back(32'h00002211);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_data", read_data, 32'h00002211);
      check("flush_count", 32'(read_count), 32'd2);
      check("flush_empty", 32'(empty), 32'd0);
      read_enable = 1'b1;
      tick();
      read_enable = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush0_empty", 32'(empty), 32'd1);
      check("flush0_count", 32'(read_count), 32'd2);
      check("flush0_data", read_data, 32'h00002211);
`endif

      repeat (3) tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
